// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single-step shift/rotate
// operations and a counted burst mode driven by a small IDLE/BURST FSM.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pdata,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_nshift,
    output logic [WIDTH-1:0] o_out,
    output logic             o_sout_msb,
    output logic             o_sout_lsb,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ASR  = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    // One step of the selected operation; unused mode codes hold the value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic             sin_l,
        input logic             sin_r
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (mode)
            MODE_SHL: res = {cur[WIDTH-2:0], sin_l};
            MODE_SHR: res = {sin_r, cur[WIDTH-1:1]};
            MODE_ROL: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR: res = {cur[0], cur[WIDTH-1:1]};
            MODE_ASR: res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:  res = cur;
        endcase
        return res;
    endfunction

    // Register all state; reset clears everything immediately, so a burst
    // interrupted by reset never produces a done pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic in priority order: load, running burst, start, step.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (i_load) begin
            out_d   = i_pdata;
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
        end else if (state_q == BURST) begin
            out_d = apply_op(mode_q, out_q, i_sin_l, i_sin_r);
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (i_start) begin
            if (i_nshift != CNT_ZERO) begin
                state_d = BURST;
                cnt_d   = i_nshift;
                mode_d  = i_mode;
            end else begin
                done_d = 1'b1;
            end
        end else if (i_en) begin
            out_d = apply_op(i_mode, out_q, i_sin_l, i_sin_r);
        end
    end

    assign o_out      = out_q;
    assign o_sout_msb = out_q[WIDTH-1];
    assign o_sout_lsb = out_q[0];
    assign o_busy     = (state_q == BURST);
    assign o_done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed, table-driven bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [2:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic       load;
    logic [7:0] pdata;
    logic       start;
    logic [3:0] nshift;
    logic [7:0] out;
    logic       sout_msb;
    logic       sout_lsb;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    typedef struct {
        logic       load;
        logic [7:0] pdata;
        logic       en;
        logic [2:0] mode;
        logic       sin_l;
        logic       sin_r;
        logic       start;
        logic [3:0] nshift;
        logic [7:0] exp_out;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_en       (en),
        .i_mode     (mode),
        .i_sin_l    (sin_l),
        .i_sin_r    (sin_r),
        .i_load     (load),
        .i_pdata    (pdata),
        .i_start    (start),
        .i_nshift   (nshift),
        .o_out      (out),
        .o_sout_msb (sout_msb),
        .o_sout_lsb (sout_lsb),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] eo, input logic eb, input logic ed);
        checkOutput({tag, " out"}, 64'(out), 64'(eo));
        checkOutput({tag, " busy"}, 64'(busy), 64'(eb));
        checkOutput({tag, " done"}, 64'(done), 64'(ed));
        checkOutput({tag, " sout_msb"}, 64'(sout_msb), 64'(eo[7]));
        checkOutput({tag, " sout_lsb"}, 64'(sout_lsb), 64'(eo[0]));
    endtask

    task automatic applyStimulus(input vec_t v);
        load   = v.load;
        pdata  = v.pdata;
        en     = v.en;
        mode   = v.mode;
        sin_l  = v.sin_l;
        sin_r  = v.sin_r;
        start  = v.start;
        nshift = v.nshift;
    endtask

    task automatic clearInputs();
        load = 1'b0; pdata = '0; en = 1'b0; mode = '0;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; nshift = '0;
    endtask

    task automatic addVec(input logic ld, input logic [7:0] pd, input logic e,
                          input logic [2:0] md, input logic sl, input logic sr,
                          input logic st, input logic [3:0] ns,
                          input logic [7:0] eo, input logic eb, input logic ed);
        vec_t v;
        v.load = ld; v.pdata = pd; v.en = e; v.mode = md; v.sin_l = sl;
        v.sin_r = sr; v.start = st; v.nshift = ns;
        v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        int done_seen;
        checks = 0;
        errors = 0;
        clearInputs();
        rstn = 1'b0;

        //     ld pdata  en mode  sl sr st ns  out   busy done
        addVec(1, 8'hA5, 0, 3'd0, 0, 0, 0, 0, 8'hA5, 0, 0);
        addVec(0, 8'h00, 1, 3'd1, 1, 0, 0, 0, 8'h4B, 0, 0);
        addVec(0, 8'h00, 1, 3'd2, 0, 1, 0, 0, 8'hA5, 0, 0);
        addVec(0, 8'h00, 1, 3'd3, 0, 0, 0, 0, 8'h4B, 0, 0);
        addVec(0, 8'h00, 1, 3'd4, 0, 0, 0, 0, 8'hA5, 0, 0);
        addVec(0, 8'h00, 1, 3'd5, 0, 0, 0, 0, 8'hD2, 0, 0);
        addVec(0, 8'h00, 1, 3'd6, 1, 1, 0, 0, 8'hD2, 0, 0);
        addVec(0, 8'h00, 0, 3'd1, 1, 1, 0, 0, 8'hD2, 0, 0);
        addVec(0, 8'h00, 1, 3'd2, 0, 0, 0, 0, 8'h69, 0, 0);
        addVec(1, 8'h81, 0, 3'd0, 0, 0, 0, 0, 8'h81, 0, 0);
        addVec(0, 8'h00, 0, 3'd4, 0, 0, 1, 3, 8'h81, 1, 0);
        addVec(0, 8'h00, 1, 3'd1, 1, 0, 1, 5, 8'hC0, 1, 0);
        addVec(0, 8'h00, 1, 3'd1, 1, 0, 1, 5, 8'h60, 1, 0);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'h30, 0, 1);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'h30, 0, 0);
        addVec(1, 8'h90, 0, 3'd0, 0, 0, 0, 0, 8'h90, 0, 0);
        addVec(0, 8'h00, 0, 3'd5, 0, 0, 1, 2, 8'h90, 1, 0);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'hC8, 1, 0);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'hE4, 0, 1);
        addVec(0, 8'h00, 0, 3'd1, 1, 0, 1, 0, 8'hE4, 0, 1);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'hE4, 0, 0);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 1, 2, 8'hE4, 1, 0);
        addVec(0, 8'h00, 1, 3'd1, 1, 1, 0, 0, 8'hE4, 1, 0);
        addVec(0, 8'h00, 1, 3'd1, 1, 1, 0, 0, 8'hE4, 0, 1);
        addVec(0, 8'h00, 0, 3'd2, 0, 1, 1, 2, 8'hE4, 1, 0);
        addVec(0, 8'h00, 0, 3'd0, 0, 1, 0, 0, 8'hF2, 1, 0);
        addVec(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'h79, 0, 1);

        // Reset state is visible without any clock edge.
        #1;
        checkAll("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            stepEdge();
            checkAll($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_done);
            @(negedge clk);
        end
        clearInputs();

        // Load during a burst aborts it with no done pulse.
        $display("[TB] burst abort by load");
        load = 1'b1; pdata = 8'h01; stepEdge(); @(negedge clk);
        load = 1'b0; start = 1'b1; mode = 3'd1; nshift = 4'd8; sin_l = 1'b0;
        stepEdge();
        checkAll("abort start", 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        clearInputs();
        stepEdge(); checkAll("abort s1", 8'h02, 1'b1, 1'b0); @(negedge clk);
        stepEdge(); checkAll("abort s2", 8'h04, 1'b1, 1'b0); @(negedge clk);
        load = 1'b1; pdata = 8'h3C;
        stepEdge();
        checkAll("abort load", 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        clearInputs();
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            stepEdge();
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort no done", 64'(done_seen), 64'd0);
        checkOutput("abort hold out", 64'(out), 64'h3C);
        @(negedge clk);

        // Count larger than WIDTH: rotate left 9 times.
        $display("[TB] long burst");
        load = 1'b1; pdata = 8'h01; stepEdge(); @(negedge clk);
        load = 1'b0; start = 1'b1; mode = 3'd3; nshift = 4'd9;
        stepEdge();
        @(negedge clk);
        clearInputs();
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            stepEdge();
            cycles++;
        end
        checkOutput("long cycles", 64'(cycles), 64'd9);
        checkAll("long end", 8'h02, 1'b0, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        load = 1'b1; pdata = 8'h81; stepEdge(); @(negedge clk);
        load = 1'b0; start = 1'b1; mode = 3'd4; nshift = 4'd3;
        stepEdge(); @(negedge clk);
        clearInputs();
        stepEdge(); @(negedge clk);
        stepEdge();
        checkAll("rst pre", 8'h60, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkAll("rst async", 8'h00, 1'b0, 1'b0);
        stepEdge();
        checkAll("rst held", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stepEdge();
            checkAll($sformatf("rst idle%0d", k), 8'h00, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2 to 64).
REQ-002 Parameter CNT_W, default 4, width of the burst shift-count input.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  single-step enable for i_mode when no burst is active.
REQ-006 i_mode  input  3  operation select: 000 hold, 001 shift left, 010 shift right, 011 rotate left, 100 rotate right, 101 arithmetic shift right, 110/111 hold.
REQ-007 i_sin_l  input  1  serial bit entering the LSB on shift left.
REQ-008 i_sin_r  input  1  serial bit entering the MSB on shift right.
REQ-009 i_load  input  1  parallel load strobe.
REQ-010 i_pdata  input  WIDTH  parallel load data.
REQ-011 i_start  input  1  burst start strobe.
REQ-012 i_nshift  input  CNT_W  burst shift count.
REQ-013 o_out  output  WIDTH  register contents.
REQ-014 o_sout_msb  output  1  equals o_out[WIDTH-1], combinational from the register.
REQ-015 o_sout_lsb  output  1  equals o_out[0], combinational from the register.
REQ-016 o_busy  output  1  high while a burst is in progress.
REQ-017 o_done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 Operations per edge: shift left {o_out[WIDTH-2:0], i_sin_l}; shift right {i_sin_r, o_out[WIDTH-1:1]}; rotate left {o_out[WIDTH-2:0], o_out[WIDTH-1]}; rotate right {o_out[0], o_out[WIDTH-1:1]}; ASR {o_out[WIDTH-1], o_out[WIDTH-1:1]}.
REQ-019 Priority per edge: i_load > active burst > i_start > i_en single step > hold.
REQ-020 i_load high: o_out <= i_pdata on that edge.
REQ-021 i_load high during a burst aborts it: o_busy low next cycle, no o_done pulse.
REQ-022 FSM states: IDLE and BURST. Reset state is IDLE.
REQ-023 IDLE with i_start=1, i_load=0, and i_nshift>0: latch i_mode and i_nshift, then go to BURST with o_busy=1 from the next cycle. No shift occurs on the start edge.
REQ-024 In BURST: exactly one latched-mode operation per edge. i_en, i_mode, i_sin are ignored except i_sin_l/i_sin_r, which are sampled live on each shift.
REQ-025 Start at edge T with count N: shifts occur on edges T+1 through T+N. o_busy is high during cycles T+1 through T+N. o_done is high for exactly the cycle after edge T+N, with o_busy low in that cycle.
REQ-026 i_start with i_nshift=0 in IDLE: no shift, state stays IDLE, o_done pulses in the next cycle.
REQ-027 i_start while in BURST is ignored and has no effect on the count.
REQ-028 A burst with latched mode hold (000/110/111) runs N cycles with no change to o_out, then pulses o_done.
REQ-029 i_nshift greater than WIDTH is legal. The operation is simply applied N times.
REQ-030 The remaining-count register is CNT_W bits wide, decrements once per burst shift, and never wraps. BURST exits when the count reaches 1 at a shift edge.
REQ-031 i_en in IDLE applies i_mode once per edge while i_en is high.

Reset
REQ-032 While i_rstn=0, regardless of clock: o_out=0, FSM=IDLE, count=0, latched mode=000, o_busy=0, o_done=0.
REQ-033 Reset asserted mid-burst clears all state immediately. No o_done is generated.
REQ-034 After i_rstn deasserts, the first edge acts normally on the current inputs.

Verification (WIDTH=8, CNT_W=4)
REQ-035 Load 8'hA5, then 1 cycle of i_en=1, mode 001, i_sin_l=1 -> o_out=8'h4B.
REQ-036 Load 8'h81, start mode 100, N=3 -> o_out goes C0, 60, 30 on successive edges. o_busy is high for 3 cycles, then o_done is high for 1 cycle.
REQ-037 Load 8'h90, start mode 101, N=2 -> o_out goes C8, then E4. o_sout_msb stays 1.
REQ-038 Load 8'h01, start mode 001, N=8, i_sin_l=0, assert i_load with 8'h3C after 2 shifts -> o_out=8'h3C, o_busy low next cycle, o_done never pulses.
REQ-039 i_start with N=0 -> o_out unchanged, o_busy stays 0, o_done pulses once on the next cycle.
REQ-040 Drop i_rstn mid-burst with o_out=8'h60 -> o_out=0 and o_busy=0 before the next clock edge. After release with no stimulus, o_out stays 0.
